// File: rtl/data_mem_access_unit_if.sv
// Request/response and Data_mem bus bundle for the load/store unit.
// slave = the access unit, master = the execute stage / memory side.
interface data_mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] Data_address;
  logic [31:0] Data_in;
  logic        we;
  logic        re;
  logic [31:0] Data_out;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, Data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, Data_address, Data_in, we, re
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, Data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, Data_address, Data_in, we, re
  );
endinterface

// File: rtl/data_mem_access_unit.sv
// Load/store initiator for Data_mem: byte/half/word loads with extension,
// word stores, and read-modify-write for sub-word stores.
module data_mem_access_unit #(
  parameter int MEM_WORDS = 256
) (
  input logic                  Clk,
  input logic                  Rst,
  data_mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t      r_state;
  logic        r_we_op;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;
  logic [31:0] r_addr;
  logic [31:0] r_din;
  logic        r_we;
  logic        r_re;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic        w_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign bus.req_ready    = (r_state == IDLE) & ~Rst;
  assign bus.Data_address = r_addr;
  assign bus.Data_in      = r_din;
  assign bus.we           = r_we;
  assign bus.re           = r_re;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_rdata    = r_rsp_rdata;
  assign bus.rsp_err      = r_rsp_err;

  // Reject at accept: illegal size, misaligned half/word, or word index past the memory.
  always_comb begin
    w_err = 1'b0;
    if (bus.req_size == 2'b11)                              w_err = 1'b1;
    if (bus.req_size == 2'b01 && bus.req_addr[0])           w_err = 1'b1;
    if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b0) w_err = 1'b1;
    if (bus.req_addr[31:2] >= 30'(MEM_WORDS))               w_err = 1'b1;
  end

  // Pick the addressed lane out of the returned word and extend it to 32 bits.
  always_comb begin
    w_byte = 8'h00;
    case (r_lane)
      2'd0: w_byte = bus.Data_out[7:0];
      2'd1: w_byte = bus.Data_out[15:8];
      2'd2: w_byte = bus.Data_out[23:16];
      2'd3: w_byte = bus.Data_out[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = r_lane[1] ? bus.Data_out[31:16] : bus.Data_out[15:0];
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = bus.Data_out;
    endcase
  end

  // Replace only the addressed lane; the rest of the word comes from memory.
  always_comb begin
    w_merged = bus.Data_out;
    if (r_size == 2'b00) begin
      case (r_lane)
        2'd0: w_merged[7:0]   = r_wdata[7:0];
        2'd1: w_merged[15:8]  = r_wdata[7:0];
        2'd2: w_merged[23:16] = r_wdata[7:0];
        2'd3: w_merged[31:24] = r_wdata[7:0];
        default: w_merged = bus.Data_out;
      endcase
    end else if (r_lane[1]) begin
      w_merged[31:16] = r_wdata;
    end else begin
      w_merged[15:0] = r_wdata;
    end
  end

  // Access sequencer; every memory strobe and response bit is registered here.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= IDLE;
      r_we_op     <= 1'b0;
      r_size      <= 2'b00;
      r_signed    <= 1'b0;
      r_lane      <= 2'b00;
      r_wdata     <= 16'h0;
      r_addr      <= 32'h0;
      r_din       <= 32'h0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we_op  <= bus.req_we;
            r_size   <= bus.req_size;
            r_signed <= bus.req_signed;
            r_lane   <= bus.req_addr[1:0];
            r_wdata  <= bus.req_wdata[15:0];
            if (w_err) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= 32'h0;
              r_state     <= RESP;
            end else begin
              r_addr <= {2'b00, bus.req_addr[31:2]};
              if (bus.req_we && bus.req_size == 2'b10) begin
                // Full-word store needs no read.
                r_din   <= bus.req_wdata;
                r_we    <= 1'b1;
                r_state <= WR;
              end else begin
                r_re    <= 1'b1;
                r_state <= RD;
              end
            end
          end
        end
        RD: begin
          r_re    <= 1'b0;
          r_state <= CAP;
        end
        CAP: begin
          if (r_we_op) begin
            r_din   <= w_merged;
            r_we    <= 1'b1;
            r_state <= WR;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_load;
            r_rsp_err   <= 1'b0;
            r_state     <= RESP;
          end
        end
        WR: begin
          r_we        <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= 32'h0;
          r_rsp_err   <= 1'b0;
          r_state     <= RESP;
        end
        RESP: begin
          r_rsp_valid <= 1'b0;
          r_rsp_rdata <= 32'h0;
          r_rsp_err   <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Bench for data_mem_access_unit: table vectors, hand-written reset and
// back-to-back sequences, then random traffic against a word-array model.
module tb_data_mem_access_unit;
  localparam int MEM_WORDS = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_access_unit_if bus ();
  data_mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (.Clk(clk), .Rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- Data_mem stand-in ----------------
  logic [31:0] dmem [MEM_WORDS];
  logic [31:0] dout;
  logic        mem_init = 1'b0;
  assign bus.Data_out = dout;

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_WORDS; i++) dmem[i] <= seed_word(i);
    end else begin
      if (bus.we && bus.Data_address < MEM_WORDS) dmem[bus.Data_address[7:0]] <= bus.Data_in;
      if (bus.re && bus.Data_address < MEM_WORDS) dout <= dmem[bus.Data_address[7:0]];
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [MEM_WORDS];

  // Predicts response, latency, strobe cycles and the stored word; updates ref_mem.
  task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat,
                       output int we_c, output int re_c, output logic [31:0] new_word);
    longint widx = longint'(a >> 2);
    int nbytes = 1 << sz;
    int shift  = 8 * int'(a % 4);
    logic [31:0] mask, v;
    rd = 0; er = 0; we_c = 0; re_c = 0; new_word = 0;
    if (sz == 3 || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0) || widx >= MEM_WORDS) begin
      er = 1; lat = 1;
      return;
    end
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * nbytes)) - 1);
    if (!w) begin
      v = (ref_mem[widx] >> shift) & mask;
      if (sg && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
      rd = v; lat = 3; re_c = 1;
    end else if (nbytes == 4) begin
      ref_mem[widx] = wd; new_word = wd; lat = 2; we_c = 1;
    end else begin
      ref_mem[widx] = (ref_mem[widx] & ~(mask << shift)) | ((wd & mask) << shift);
      new_word = ref_mem[widx]; lat = 4; re_c = 1; we_c = 3;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid = 1'b1; bus.req_we = w; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
  endtask

  // One request from IDLE: checks timing, strobes and addresses against the model.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
    logic [31:0] m_rd, m_word, we_addr, re_addr, we_data;
    logic m_er;
    int m_lat, m_we, m_re, lat, we_c, re_c, we_n, re_n;
    model(w, sz, sg, a, wd, m_rd, m_er, m_lat, m_we, m_re, m_word);
    @(negedge clk);
    chk("ready_before", 32'(bus.req_ready), 1);
    drive_req(w, sz, sg, a, wd);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0; we_c = 0; re_c = 0; we_n = 0; re_n = 0;
    we_addr = 0; re_addr = 0; we_data = 0; rd = 0; er = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.we) begin we_c = k; we_n++; we_addr = bus.Data_address; we_data = bus.Data_in; end
      if (bus.re) begin re_c = k; re_n++; re_addr = bus.Data_address; end
      if (bus.rsp_valid) begin lat = k; rd = bus.rsp_rdata; er = bus.rsp_err; end
    end
    chk("rsp_latency", 32'(lat), 32'(m_lat));
    chk("we_cycle", 32'(we_c), 32'(m_we));
    chk("re_cycle", 32'(re_c), 32'(m_re));
    chk("we_count", 32'(we_n), (m_we != 0) ? 1 : 0);
    chk("re_count", 32'(re_n), (m_re != 0) ? 1 : 0);
    if (m_we != 0) begin
      chk("we_addr", we_addr, {2'b00, a[31:2]});
      chk("we_data", we_data, m_word);
    end
    if (m_re != 0) chk("re_addr", re_addr, {2'b00, a[31:2]});
    chk("model_rdata", rd, m_rd);
    chk("model_err", 32'(er), 32'(m_er));
    @(negedge clk);
    chk("rsp_pulse_end", 32'(bus.rsp_valid), 0);
    chk("rdata_cleared", bus.rsp_rdata, 0);
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eer;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [31:0] rd, exp_rd, m_word;
    logic er, exp_er;
    int m_lat, m_we, m_re, rsp_n, we_n, re_n, idx;
    logic [31:0] q_rd [$];
    logic        q_er [$];
    vec_t        b2b [3];

    tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 2'b00, 1'b1, 32'h11,  32'h0,        32'hFFFFFFBE, 1'b0};
    tbl[3]  = '{1'b0, 2'b00, 1'b0, 32'h11,  32'h0,        32'h000000BE, 1'b0};
    tbl[4]  = '{1'b0, 2'b01, 1'b1, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0};
    tbl[5]  = '{1'b1, 2'b00, 1'b0, 32'h13,  32'h55,       32'h0,        1'b0};
    tbl[6]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h55ADBEEF, 1'b0};
    tbl[7]  = '{1'b1, 2'b01, 1'b0, 32'h10,  32'h1234,     32'h0,        1'b0};
    tbl[8]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h55AD1234, 1'b0};
    tbl[9]  = '{1'b0, 2'b10, 1'b0, 32'h02,  32'h0,        32'h0,        1'b1};
    tbl[10] = '{1'b1, 2'b01, 1'b0, 32'h11,  32'hFFFF,     32'h0,        1'b1};
    tbl[11] = '{1'b1, 2'b11, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1};
    tbl[12] = '{1'b1, 2'b10, 1'b0, 32'(4*MEM_WORDS), 32'h1, 32'h0,      1'b1};
    tbl[13] = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h55AD1234, 1'b0};

    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = seed_word(i);
    bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0;
    bus.req_signed = 0; bus.req_addr = 0; bus.req_wdata = 0;

    // Reset state
    mem_init = 1'b1;
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    chk("rst_we", 32'(bus.we), 0);
    chk("rst_re", 32'(bus.re), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_addr", bus.Data_address, 0);
    chk("rst_din", bus.Data_in, 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.req_ready), 1);

    // Directed table
    for (int i = 0; i < 14; i++) begin
      issue(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, rd, er);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].erd);
      chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].eer));
    end

    // Reset mid-load: strobes drop at once, no response, ready after release
    @(negedge clk);
    drive_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("midload_re", 32'(bus.re), 1);
    rst = 1'b1;
    #1;
    chk("midload_rst_re", 32'(bus.re), 0);
    chk("midload_rst_we", 32'(bus.we), 0);
    chk("midload_rst_rsp", 32'(bus.rsp_valid), 0);
    chk("midload_rst_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    rsp_n = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) rsp_n++;
    end
    chk("midload_no_rsp", 32'(rsp_n), 0);
    chk("midload_ready", 32'(bus.req_ready), 1);

    // Reset during the write cycle of a byte store: memory must stay intact
    @(negedge clk);
    drive_req(1'b1, 2'b00, 1'b0, 32'h21, 32'hA5);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rmw_we_pulse", 32'(bus.we), 1);
    rst = 1'b1;
    #1;
    chk("rmw_rst_we", 32'(bus.we), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er);
    chk("rmw_abort_mem", rd, seed_word(8));

    // Back-to-back with req_valid held high
    b2b[0] = '{1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, 32'h0, 1'b0};
    b2b[1] = '{1'b0, 2'b00, 1'b0, 32'h41, 32'h0,        32'h0, 1'b0};
    b2b[2] = '{1'b1, 2'b01, 1'b0, 32'h42, 32'hABCD,     32'h0, 1'b0};
    @(negedge clk);
    idx = 0; rsp_n = 0; we_n = 0; re_n = 0;
    drive_req(b2b[0].w, b2b[0].sz, b2b[0].sg, b2b[0].a, b2b[0].wd);
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (bus.we) we_n++;
      if (bus.re) re_n++;
      if (bus.we && bus.re) chk("b2b_we_re_overlap", 1, 0);
      if (bus.rsp_valid) begin
        rsp_n++;
        if (q_rd.size() == 0) chk("b2b_unexpected_rsp", 1, 0);
        else begin
          exp_rd = q_rd.pop_front();
          exp_er = q_er.pop_front();
          chk($sformatf("b2b_rdata%0d", rsp_n), bus.rsp_rdata, exp_rd);
          chk($sformatf("b2b_err%0d", rsp_n), 32'(bus.rsp_err), 32'(exp_er));
        end
        if (bus.req_ready) chk("b2b_ready_in_resp", 1, 0);
      end
      if (bus.req_ready && idx < 3) begin
        model(b2b[idx].w, b2b[idx].sz, b2b[idx].sg, b2b[idx].a, b2b[idx].wd,
              exp_rd, exp_er, m_lat, m_we, m_re, m_word);
        q_rd.push_back(exp_rd);
        q_er.push_back(exp_er);
        idx++;
        @(posedge clk);
        #1;
        if (idx < 3) drive_req(b2b[idx].w, b2b[idx].sz, b2b[idx].sg, b2b[idx].a, b2b[idx].wd);
        else bus.req_valid = 1'b0;
      end
    end
    chk("b2b_rsp_count", 32'(rsp_n), 3);
    chk("b2b_we_count", 32'(we_n), 2);
    chk("b2b_re_count", 32'(re_n), 2);
    chk("b2b_final_word", ref_mem[16], 32'hABCD3344);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      if ($urandom_range(0, 15) == 0) a = $urandom;
      else a = $urandom_range(0, 4 * MEM_WORDS + 15);
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && sz == 2'b10) a[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0 && sz == 2'b01) a[0] = 1'b0;
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, rd, er);
    end

    // Whole-memory comparison against the model
    @(negedge clk);
    we_n = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (dmem[i] !== ref_mem[i]) we_n++;
    chk("mem_mismatch_words", 32'(we_n), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time guard
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
